// File: rtl/cfg_bus_pkg.sv
// +------------------------------------------------------------------+
// | cfg_bus_pkg: constants and helpers shared by both ends of the    |
// | configuration bus.                                    rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

package cfg_bus_pkg;

  localparam int unsigned CFG_ADDR_W = 3;
  localparam int unsigned CFG_DATA_W = 32;

  localparam logic RESP_OK        = 1'b0;
  localparam logic RESP_ERR_RANGE = 1'b1;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_kind_e;

  // Register indices are dense from zero, so anything at or past the count is unmapped.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned nregs);
    return addr < nregs;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_reg_cell.sv
// +------------------------------------------------------------------+
// | cfg_reg_cell: one configuration register with reset value and    |
// | registered update pulse.                              rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module cfg_reg_cell
  import cfg_bus_pkg::*;
#(
  parameter int unsigned WIDTH = CFG_DATA_W,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q,
  output logic             upd
);

  // The pulse follows every write, including ones that leave the value unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q   <= INIT;
      upd <= 1'b0;
    end else begin
      upd <= we;
      if (we) begin
        q <= wdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cfg_reg_target.sv
// +------------------------------------------------------------------+
// | cfg_reg_target: valid/ready register bank target with one-entry  |
// | response stage and flat configuration outputs.        rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module cfg_reg_target
  import cfg_bus_pkg::*;
#(
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = CFG_ADDR_W,
  parameter int unsigned DATA_W = CFG_DATA_W,
  parameter logic [NREGS*DATA_W-1:0] INIT = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WRITE,
  input  logic [ADDR_W-1:0]       REQ_ADDR,
  input  logic [DATA_W-1:0]       REQ_DATA,
  output logic                    RESP_VALID,
  input  logic                    RESP_READY,
  output logic [DATA_W-1:0]       RESP_DATA,
  output logic                    RESP_ERR,
  output logic [NREGS*DATA_W-1:0] CFG_OUT,
  output logic [NREGS-1:0]        CFG_UPD
);

  logic              fire;
  logic              in_range;
  logic [NREGS-1:0]  wr_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] reg_q [NREGS];

  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;

  // Ready depends only on the response stage, never on the request fields.
  assign REQ_READY = !RST && (!resp_valid_q || RESP_READY);
  assign fire      = REQ_VALID && REQ_READY;
  assign in_range  = addr_in_range(32'(REQ_ADDR), NREGS);

  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
      assign wr_en[i] = fire && (REQ_WRITE == REQ_WR) && (REQ_ADDR == ADDR_W'(i));

      cfg_reg_cell #(
        .WIDTH (DATA_W),
        .INIT  (INIT[i*DATA_W +: DATA_W])
      ) u_cell (
        .CLK   (CLK),
        .RST   (RST),
        .we    (wr_en[i]),
        .wdata (REQ_DATA),
        .q     (reg_q[i]),
        .upd   (CFG_UPD[i])
      );

      assign CFG_OUT[i*DATA_W +: DATA_W] = reg_q[i];
    end
  endgenerate

  // Unmapped addresses match no index and fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (REQ_ADDR == ADDR_W'(i)) begin
        rd_data = reg_q[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= RESP_OK;
    end else if (fire) begin
      resp_valid_q <= 1'b1;
      resp_err_q   <= in_range ? RESP_OK : RESP_ERR_RANGE;
      resp_data_q  <= (in_range && (REQ_WRITE == REQ_RD)) ? rd_data : '0;
    end else if (RESP_READY) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign RESP_VALID = resp_valid_q;
  assign RESP_DATA  = resp_data_q;
  assign RESP_ERR   = resp_err_q;

endmodule

`default_nettype wire
